fifo_burst_reader: RTL and testbench

Single-clock read-side controller for the team's 16-bit asynchronous FIFO: drains a programmed number of words from the FIFO read port and presents them on a valid/ready stream with a last-beat marker. It sits in the read clock domain, driving the FIFO read enable and absorbing the FIFO's one-cycle registered read latency. Downstream backpressure never loses or duplicates a word.

---
 rtl/fifo_burst_reader_pkg.sv | 8 +
 rtl/stream_skid_buf.sv | 33 +++
 rtl/fifo_burst_reader.sv | 67 ++++++
 tb/tb_fifo_burst_reader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// fifo_rd_pkg: shared state encoding and sizing constants for the FIFO burst reader.
package fifo_rd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W = 10;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry in-order buffer; entry e0 is always the head.
module stream_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  cnt
);
    logic [DATA_W-1:0] e0, e1;
    assign head = e0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10: if (cnt == CNT_W'(0)) e0 <= din; else e1 <= din;
                2'b01: e0 <= e1;
                // simultaneous push/pop: the new word lands behind whatever stays
                2'b11: if (cnt == CNT_W'(1)) e0 <= din; else begin e0 <= e1; e1 <= din; end
                default: ;
            endcase
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains burst_len words from a registered-output FIFO onto a
// valid/ready stream, absorbing the one-cycle read latency with a 2-entry buffer.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_ren,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);
    state_t           state;
    logic [LEN_W-1:0] req_left, acc_left;
    logic             inflight, accept;
    logic [CNT_W-1:0] buf_cnt;
    // a read is only issued when its word is guaranteed a buffer slot
    assign fifo_ren = (state == RUN) && (req_left != '0) && !fifo_empty &&
                      ((buf_cnt + CNT_W'(inflight)) < CNT_W'(BUF_DEPTH));
    assign m_valid  = buf_cnt != '0;
    assign m_last   = m_valid && (acc_left == LEN_W'(1));
    assign accept   = m_valid && m_ready;
    assign busy     = state == RUN;
    assign done     = state == DONE;
    stream_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .din  (fifo_dout),
        .pop  (accept),
        .head (m_data),
        .cnt  (buf_cnt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_left <= '0;
            acc_left <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_ren;
            case (state)
                IDLE: if (start && burst_len != '0) begin
                    state    <= RUN;
                    req_left <= burst_len;
                    acc_left <= burst_len;
                end
                RUN: begin
                    if (fifo_ren) req_left <= req_left - LEN_W'(1);
                    if (accept) acc_left <= acc_left - LEN_W'(1);
                    if (accept && m_last) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed vector table plus hand-written corner sequences,
// with a bench-side FIFO model and a per-cycle stream monitor.
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;
    localparam int DW = 16;
    localparam int LW = 10;
    typedef struct {
        logic [DW-1:0] base;
        int            nwords;
        int            len;
        int            mode;
    } vec_t;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic          fifo_empty, fifo_ren, m_valid, m_last, busy, done;
    logic [LW-1:0] burst_len = '0;
    logic [DW-1:0] fifo_dout = '0, m_data, hold_data;
    logic [DW-1:0] mem [0:63];
    logic [DW:0]   beats [$];
    int wp = 0, rp = 0, total = 0, bad = 0;
    int ren_cnt = 0, done_cnt = 0, busy_cnt = 0, occ = 0, mode = 0, first_idx;
    logic hold = 1'b0;
    vec_t vecs [5];

    always #5 clk = ~clk;
    assign fifo_empty = (rp == wp);

    fifo_burst_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_ren(fifo_ren),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    always @(posedge clk) if (fifo_ren && rp != wp) begin
        fifo_dout <= mem[rp];
        rp <= rp + 1;
    end

    always @(posedge clk) begin
        #1;
        case (mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    function automatic void chk(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
            hold = 1'b0;
        end else begin
            if (fifo_ren) begin
                chk("credit", int'(occ < BUF_DEPTH), 1);
                chk("ren_while_empty", int'(fifo_empty), 0);
                ren_cnt++;
            end
            if (hold) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_data", int'(m_data), int'(hold_data));
            end
            hold = m_valid && !m_ready;
            hold_data = m_data;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (m_valid && m_ready) beats.push_back({m_last, m_data});
            occ = occ + int'(fifo_ren) - int'(m_valid && m_ready);
        end
    end

    task automatic clear_stats();
        beats.delete();
        ren_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk); #1;
        start = 1'b1;
        burst_len = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int n = 0; n < lim && done_cnt == 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_beats(input logic [DW-1:0] base, input int len);
        chk("beat_count", beats.size(), len);
        for (int i = 0; i < beats.size() && i < len; i++) begin
            chk("beat_data", int'(beats[i][DW-1:0]), int'(base + DW'(i)));
            chk("beat_last", int'(beats[i][DW]), int'(i == len - 1));
        end
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.nwords; i++) begin
            mem[wp] = v.base + DW'(i);
            wp++;
        end
        clear_stats();
        mode = v.mode;
        pulse_start(v.len);
        wait_done(v.len == 0 ? 20 : 300);
        check_beats(v.base, v.len);
        chk("ren_count", ren_cnt, v.len);
        chk("done_count", done_cnt, int'(v.len != 0));
        chk("busy_seen", int'(busy_cnt != 0), int'(v.len != 0));
        chk("idle_after", int'(busy), 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ren"}, int'(fifo_ren), 0);
        chk({tag, "_valid"}, int'(m_valid), 0);
        chk({tag, "_data"}, int'(m_data), 0);
        chk({tag, "_last"}, int'(m_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        vecs[0] = '{base: 16'h1000, nwords: 4, len: 4, mode: 0};
        vecs[1] = '{base: 16'h2000, nwords: 8, len: 8, mode: 1};
        vecs[2] = '{base: 16'h3000, nwords: 2, len: 0, mode: 0};
        vecs[3] = '{base: 16'h3000, nwords: 0, len: 2, mode: 2};
        vecs[4] = '{base: 16'h5000, nwords: 1, len: 1, mode: 2};
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        rst_n = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i]);

        // start with an empty FIFO; words trickle in at random gaps
        clear_stats();
        mode = 0;
        pulse_start(3);
        repeat (4) @(posedge clk);
        #1;
        chk("empty_stall_ren", ren_cnt, 0);
        chk("empty_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            mem[wp] = 16'h8000 + DW'(i);
            wp++;
        end
        wait_done(200);
        check_beats(16'h8000, 3);
        chk("empty_done", done_cnt, 1);
        chk("empty_ren", ren_cnt, 3);

        // second start while busy must not resample burst_len
        for (int i = 0; i < 5; i++) begin
            mem[wp] = 16'h7000 + DW'(i);
            wp++;
        end
        clear_stats();
        mode = 3;
        pulse_start(2);
        pulse_start(5);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_valid", int'(m_valid), 1);
        chk("bp_head", int'(m_data), 16'h7000);
        chk("bp_last", int'(m_last), 0);
        chk("bp_ren", int'(fifo_ren), 0);
        mode = 0;
        wait_done(100);
        check_beats(16'h7000, 2);
        chk("restart_ren", ren_cnt, 2);
        chk("restart_done", done_cnt, 1);
        run_vec('{base: 16'h7002, nwords: 0, len: 3, mode: 0});

        // reset in the middle of a 6-word burst
        first_idx = wp;
        for (int i = 0; i < 6; i++) begin
            mem[wp] = 16'h9000 + DW'(i);
            wp++;
        end
        clear_stats();
        mode = 0;
        pulse_start(6);
        for (int n = 0; n < 50 && beats.size() < 2; n++) @(negedge clk);
        chk("pre_reset_beats", beats.size(), 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_quiet("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_popped", int'(rp - first_idx >= 3), 1);
        run_vec('{base: 16'h9000 + DW'(rp - first_idx), nwords: 0, len: 2, mode: 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
